// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side status in, stall/flush/forward controls out.
// master = pipeline datapath, slave = hazard controller.
interface hazard_ctrl_if #(
    parameter int NSTAGES = 4,
    parameter int REGW    = 5,
    parameter int CNTW    = 16
);
    logic                ihit;
    logic                dhit;
    logic                mem_dren;
    logic                mem_dwen;
    logic [REGW-1:0]     id_rs;
    logic [REGW-1:0]     id_rt;
    logic [REGW-1:0]     ex_rs;
    logic [REGW-1:0]     ex_rt;
    logic [REGW-1:0]     ex_rd;
    logic                ex_wen;
    logic                ex_memread;
    logic [REGW-1:0]     mem_rd;
    logic                mem_wen;
    logic [REGW-1:0]     wb_rd;
    logic                wb_wen;
    logic                ex_redirect;
    logic                halt;
    logic                pc_en;
    logic [NSTAGES-1:0]  stage_en;
    logic [NSTAGES-1:0]  stage_flush;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic [CNTW-1:0]     stall_cnt;
    logic [CNTW-1:0]     flush_cnt;
    logic                halted;

    modport master (
        output ihit, dhit, mem_dren, mem_dwen,
        output id_rs, id_rt, ex_rs, ex_rt, ex_rd,
        output ex_wen, ex_memread,
        output mem_rd, mem_wen, wb_rd, wb_wen,
        output ex_redirect, halt,
        input  pc_en, stage_en, stage_flush,
        input  fwd_a, fwd_b,
        input  stall_cnt, flush_cnt, halted
    );

    modport slave (
        input  ihit, dhit, mem_dren, mem_dwen,
        input  id_rs, id_rt, ex_rs, ex_rt, ex_rd,
        input  ex_wen, ex_memread,
        input  mem_rd, mem_wen, wb_rd, wb_wen,
        input  ex_redirect, halt,
        output pc_en, stage_en, stage_flush,
        output fwd_a, fwd_b,
        output stall_cnt, flush_cnt, halted
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and operand-forwarding control for an
// in-order pipeline with NSTAGES latches, plus stall/flush counters.
module hazard_ctrl #(
    parameter int NSTAGES = 4,
    parameter int REGW    = 5,
    parameter int FWD_EN  = 1,
    parameter int CNTW    = 16
) (
    input logic          CLK,
    input logic          nRST,
    hazard_ctrl_if.slave hif
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DWAIT = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               lu_q, lu_d;
    logic [CNTW-1:0]    stall_q, stall_d;
    logic [CNTW-1:0]    flush_q, flush_d;

    logic               pc_en_c;
    logic [NSTAGES-1:0] en_c;
    logic [NSTAGES-1:0] fl_c;
    logic               stall_ev, flush_ev;
    logic               dwait, lu_hit, ilk_hit;
    logic               ev_halt, ev_wait, ev_redir;
    logic               ev_lu, ev_miss, ev_norm;

    function automatic logic id_hit(
        input logic [REGW-1:0] rd,
        input logic [REGW-1:0] rs,
        input logic [REGW-1:0] rt
    );
        return (rd != '0) && ((rd == rs) || (rd == rt));
    endfunction

    function automatic logic [1:0] fsel(
        input logic [REGW-1:0] r,
        input logic [REGW-1:0] mrd,
        input logic            mw,
        input logic [REGW-1:0] wrd,
        input logic            ww
    );
        if (mw && (mrd != '0) && (mrd == r)) return 2'b01;
        if (ww && (wrd != '0) && (wrd == r)) return 2'b10;
        return 2'b00;
    endfunction

    // lu_q masks the load still sitting in EX after its bubble was inserted
    always_comb begin
        dwait   = !hif.dhit &&
                  ((state_q == DWAIT) || hif.mem_dren || hif.mem_dwen);
        lu_hit  = hif.ex_memread && !lu_q &&
                  id_hit(hif.ex_rd, hif.id_rs, hif.id_rt);
        ilk_hit = (FWD_EN == 0) &&
                  ((hif.ex_wen && id_hit(hif.ex_rd, hif.id_rs, hif.id_rt)) ||
                   (hif.mem_wen && id_hit(hif.mem_rd, hif.id_rs, hif.id_rt)));
        ev_halt  = (state_q == HALT) || hif.halt;
        ev_wait  = !ev_halt && dwait;
        ev_redir = !ev_halt && !dwait && hif.ex_redirect;
        ev_lu    = !ev_halt && !dwait && !hif.ex_redirect &&
                   (lu_hit || ilk_hit);
        ev_miss  = !ev_halt && !dwait && !hif.ex_redirect &&
                   !(lu_hit || ilk_hit) && !hif.ihit;
        ev_norm  = !(ev_halt || ev_wait || ev_redir || ev_lu || ev_miss);
    end

    always_comb begin
        state_d  = RUN;
        lu_d     = 1'b0;
        pc_en_c  = 1'b1;
        en_c     = '1;
        fl_c     = '0;
        stall_ev = 1'b0;
        flush_ev = 1'b0;
        unique case (1'b1)
            ev_halt: begin
                state_d = HALT;
                lu_d    = lu_q;
                pc_en_c = 1'b0;
                en_c    = '0;
            end
            ev_wait: begin
                state_d  = DWAIT;
                lu_d     = lu_q;
                pc_en_c  = 1'b0;
                en_c     = '0;
                stall_ev = 1'b1;
            end
            ev_redir: begin
                fl_c[1:0] = 2'b11;
                flush_ev  = 1'b1;
            end
            ev_lu: begin
                lu_d     = lu_hit;
                pc_en_c  = 1'b0;
                en_c[0]  = 1'b0;
                fl_c[1]  = 1'b1;
                stall_ev = 1'b1;
            end
            ev_miss: begin
                pc_en_c  = 1'b0;
                fl_c[0]  = 1'b1;
                stall_ev = 1'b1;
            end
            ev_norm: begin
            end
            default: begin
            end
        endcase
        stall_d = (stall_ev && (stall_q != '1)) ? stall_q + CNTW'(1)
                                                : stall_q;
        flush_d = (flush_ev && (flush_q != '1)) ? flush_q + CNTW'(1)
                                                : flush_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            lu_q    <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            lu_q    <= lu_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // every control output is held inactive while reset is asserted
    always_comb begin
        hif.pc_en       = nRST && pc_en_c;
        hif.stage_en    = nRST ? en_c : '0;
        hif.stage_flush = nRST ? fl_c : '0;
        hif.fwd_a       = 2'b00;
        hif.fwd_b       = 2'b00;
        if (nRST && (FWD_EN != 0)) begin
            hif.fwd_a = fsel(hif.ex_rs, hif.mem_rd, hif.mem_wen,
                             hif.wb_rd, hif.wb_wen);
            hif.fwd_b = fsel(hif.ex_rt, hif.mem_rd, hif.mem_wen,
                             hif.wb_rd, hif.wb_wen);
        end
        hif.stall_cnt   = stall_q;
        hif.flush_cnt   = flush_q;
        hif.halted      = (state_q == HALT);
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, directed corner sequences and a
// randomized run against a rule-level reference model.
module tb_hazard_ctrl;
    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl_if #(.NSTAGES(4), .REGW(5), .CNTW(16)) hif ();
    hazard_ctrl_if #(.NSTAGES(4), .REGW(5), .CNTW(16)) if0 ();
    hazard_ctrl_if #(.NSTAGES(4), .REGW(5), .CNTW(3))  ifs ();

    hazard_ctrl #(.NSTAGES(4), .REGW(5), .FWD_EN(1), .CNTW(16)) dut (
        .CLK(CLK), .nRST(nRST), .hif(hif.slave));
    hazard_ctrl #(.NSTAGES(4), .REGW(5), .FWD_EN(0), .CNTW(16)) dut0 (
        .CLK(CLK), .nRST(nRST), .hif(if0.slave));
    hazard_ctrl #(.NSTAGES(4), .REGW(5), .FWD_EN(1), .CNTW(3)) duts (
        .CLK(CLK), .nRST(nRST), .hif(ifs.slave));

    always_comb begin
        if0.ihit = hif.ihit;               ifs.ihit = hif.ihit;
        if0.dhit = hif.dhit;               ifs.dhit = hif.dhit;
        if0.mem_dren = hif.mem_dren;       ifs.mem_dren = hif.mem_dren;
        if0.mem_dwen = hif.mem_dwen;       ifs.mem_dwen = hif.mem_dwen;
        if0.id_rs = hif.id_rs;             ifs.id_rs = hif.id_rs;
        if0.id_rt = hif.id_rt;             ifs.id_rt = hif.id_rt;
        if0.ex_rs = hif.ex_rs;             ifs.ex_rs = hif.ex_rs;
        if0.ex_rt = hif.ex_rt;             ifs.ex_rt = hif.ex_rt;
        if0.ex_rd = hif.ex_rd;             ifs.ex_rd = hif.ex_rd;
        if0.ex_wen = hif.ex_wen;           ifs.ex_wen = hif.ex_wen;
        if0.ex_memread = hif.ex_memread;   ifs.ex_memread = hif.ex_memread;
        if0.mem_rd = hif.mem_rd;           ifs.mem_rd = hif.mem_rd;
        if0.mem_wen = hif.mem_wen;         ifs.mem_wen = hif.mem_wen;
        if0.wb_rd = hif.wb_rd;             ifs.wb_rd = hif.wb_rd;
        if0.wb_wen = hif.wb_wen;           ifs.wb_wen = hif.wb_wen;
        if0.ex_redirect = hif.ex_redirect; ifs.ex_redirect = hif.ex_redirect;
        if0.halt = hif.halt;               ifs.halt = hif.halt;
    end

    typedef struct {
        logic ihit, dhit, dren, dwen, ex_wen, ex_memread;
        logic mem_wen, wb_wen, redir, halt;
        logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    } in_t;
    typedef struct {
        logic pc_en;
        logic [3:0] en, fl;
        logic [1:0] fa, fb;
    } out_t;
    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;
    typedef enum {M_RUN, M_DWAIT, M_HALT} mst_e;
    typedef struct {
        mst_e st;
        bit   lu;
        int   scnt, fcnt;
    } ms_t;

    vec_t vq[$];

    function automatic in_t idle();
        in_t t;
        t.ihit = 1'b1; t.dhit = 1'b0; t.dren = 1'b0; t.dwen = 1'b0;
        t.ex_wen = 1'b0; t.ex_memread = 1'b0; t.mem_wen = 1'b0;
        t.wb_wen = 1'b0; t.redir = 1'b0; t.halt = 1'b0;
        t.id_rs = '0; t.id_rt = '0; t.ex_rs = '0; t.ex_rt = '0;
        t.ex_rd = '0; t.mem_rd = '0; t.wb_rd = '0;
        return t;
    endfunction

    function automatic in_t rnd();
        in_t t;
        t.ihit = ($urandom_range(0, 7) != 0);
        t.dhit = ($urandom_range(0, 2) != 0);
        t.dren = ($urandom_range(0, 3) == 0);
        t.dwen = ($urandom_range(0, 5) == 0);
        t.ex_wen = 1'($urandom_range(0, 1));
        t.ex_memread = 1'($urandom_range(0, 1));
        t.mem_wen = 1'($urandom_range(0, 1));
        t.wb_wen = 1'($urandom_range(0, 1));
        t.redir = ($urandom_range(0, 7) == 0);
        t.halt = ($urandom_range(0, 63) == 0);
        t.id_rs = 5'($urandom_range(0, 3)); t.id_rt = 5'($urandom_range(0, 3));
        t.ex_rs = 5'($urandom_range(0, 3)); t.ex_rt = 5'($urandom_range(0, 3));
        t.ex_rd = 5'($urandom_range(0, 3)); t.mem_rd = 5'($urandom_range(0, 3));
        t.wb_rd = 5'($urandom_range(0, 3));
        return t;
    endfunction

    function automatic out_t mk(logic pc, logic [3:0] en, logic [3:0] fl,
                                logic [1:0] fa, logic [1:0] fb);
        out_t o;
        o.pc_en = pc; o.en = en; o.fl = fl; o.fa = fa; o.fb = fb;
        return o;
    endfunction

    task automatic add(input string n, input in_t t, input out_t o);
        vec_t v;
        v.name = n; v.i = t; v.o = o;
        vq.push_back(v);
    endtask

    task automatic drive(input in_t t);
        hif.ihit = t.ihit; hif.dhit = t.dhit;
        hif.mem_dren = t.dren; hif.mem_dwen = t.dwen;
        hif.id_rs = t.id_rs; hif.id_rt = t.id_rt;
        hif.ex_rs = t.ex_rs; hif.ex_rt = t.ex_rt; hif.ex_rd = t.ex_rd;
        hif.ex_wen = t.ex_wen; hif.ex_memread = t.ex_memread;
        hif.mem_rd = t.mem_rd; hif.mem_wen = t.mem_wen;
        hif.wb_rd = t.wb_rd; hif.wb_wen = t.wb_wen;
        hif.ex_redirect = t.redir; hif.halt = t.halt;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic out_t get_main();
        return mk(hif.pc_en, hif.stage_en, hif.stage_flush,
                  hif.fwd_a, hif.fwd_b);
    endfunction

    function automatic out_t get0();
        return mk(if0.pc_en, if0.stage_en, if0.stage_flush,
                  if0.fwd_a, if0.fwd_b);
    endfunction

    task automatic cmp(input string tag, input out_t a, input out_t e);
        chk({tag, ".pc_en"}, 32'(a.pc_en), 32'(e.pc_en));
        chk({tag, ".stage_en"}, 32'(a.en), 32'(e.en));
        chk({tag, ".stage_flush"}, 32'(a.fl), 32'(e.fl));
        chk({tag, ".fwd_a"}, 32'(a.fa), 32'(e.fa));
        chk({tag, ".fwd_b"}, 32'(a.fb), 32'(e.fb));
    endtask

    function automatic int sat(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [1:0] fsel(logic [4:0] r, in_t i);
        if (i.mem_wen && i.mem_rd != 0 && i.mem_rd == r) return 2'b01;
        if (i.wb_wen && i.wb_rd != 0 && i.wb_rd == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit reads(logic [4:0] rd, in_t i);
        return (rd != 0) && (rd == i.id_rs || rd == i.id_rt);
    endfunction

    function automatic ms_t mreset();
        ms_t m;
        m.st = M_RUN; m.lu = 1'b0; m.scnt = 0; m.fcnt = 0;
        return m;
    endfunction

    // Rule-level model: priority HALT > data wait > redirect > RAW > fetch miss
    function automatic void model(input in_t i, input ms_t m, input bit fe,
                                  output out_t o, output ms_t n);
        bit lu, il;
        n = m;
        o = mk(1'b1, 4'hF, 4'h0, 2'b00, 2'b00);
        if (fe) begin
            o.fa = fsel(i.ex_rs, i);
            o.fb = fsel(i.ex_rt, i);
        end
        lu = i.ex_memread && reads(i.ex_rd, i) && !m.lu;
        il = !fe && ((i.ex_wen && reads(i.ex_rd, i)) ||
                     (i.mem_wen && reads(i.mem_rd, i)));
        if (m.st == M_HALT || i.halt) begin
            o.pc_en = 1'b0; o.en = 4'h0;
            n.st = M_HALT;
        end else if (!i.dhit && (m.st == M_DWAIT || i.dren || i.dwen)) begin
            o.pc_en = 1'b0; o.en = 4'h0;
            n.st = M_DWAIT; n.scnt = m.scnt + 1;
        end else begin
            n.st = M_RUN; n.lu = 1'b0;
            if (i.redir) begin
                o.fl = 4'h3; n.fcnt = m.fcnt + 1;
            end else if (lu || il) begin
                o.pc_en = 1'b0; o.en = 4'hE; o.fl = 4'h2;
                n.lu = lu; n.scnt = m.scnt + 1;
            end else if (!i.ihit) begin
                o.pc_en = 1'b0; o.fl = 4'h1; n.scnt = m.scnt + 1;
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        drive(idle());
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        in_t  t;
        out_t e1, e0;
        ms_t  m1, m0, n1, n0;

        drive(idle());
        #1;
        cmp("reset", get_main(), mk(0, 4'h0, 4'h0, 0, 0));
        chk("reset.halted", 32'(hif.halted), 0);
        chk("reset.stall_cnt", 32'(hif.stall_cnt), 0);
        chk("reset.flush_cnt", 32'(hif.flush_cnt), 0);

        t = idle();
        add("normal", t, mk(1, 4'hF, 4'h0, 0, 0));
        t = idle(); t.ihit = 0;
        add("imiss", t, mk(0, 4'hF, 4'h1, 0, 0));
        t = idle(); t.ex_memread = 1; t.ex_rd = 5; t.id_rt = 5;
        add("loaduse", t, mk(0, 4'hE, 4'h2, 0, 0));
        t = idle(); t.ex_memread = 1; t.ex_rd = 0;
        add("loaduse_r0", t, mk(1, 4'hF, 4'h0, 0, 0));
        t = idle(); t.ex_memread = 1; t.ex_rd = 5; t.id_rs = 5; t.redir = 1;
        add("redir_lu", t, mk(1, 4'hF, 4'h3, 0, 0));
        t = idle(); t.dren = 1; t.redir = 1;
        add("dwait_redir", t, mk(0, 4'h0, 4'h0, 0, 0));
        t = idle(); t.dren = 1; t.dhit = 1;
        add("dhit", t, mk(1, 4'hF, 4'h0, 0, 0));
        t = idle(); t.mem_wen = 1; t.wb_wen = 1;
        t.mem_rd = 7; t.wb_rd = 7; t.ex_rs = 7;
        add("fwd_mem", t, mk(1, 4'hF, 4'h0, 2'b01, 0));
        t = idle(); t.mem_wen = 1; t.wb_wen = 1;
        add("fwd_r0", t, mk(1, 4'hF, 4'h0, 0, 0));
        t = idle(); t.wb_wen = 1; t.wb_rd = 4; t.ex_rt = 4;
        add("fwd_wb_b", t, mk(1, 4'hF, 4'h0, 0, 2'b10));
        t = idle(); t.mem_rd = 6; t.ex_rs = 6; t.wb_wen = 1; t.wb_rd = 6;
        add("fwd_memoff", t, mk(1, 4'hF, 4'h0, 2'b10, 0));
        t = idle(); t.halt = 1; t.redir = 1;
        add("halt", t, mk(0, 4'h0, 4'h0, 0, 0));
        t = idle(); t.dwen = 1;
        add("store_wait", t, mk(0, 4'h0, 4'h0, 0, 0));
        t = idle(); t.ihit = 0; t.ex_memread = 1; t.ex_rd = 2; t.id_rs = 2;
        add("lu_over_imiss", t, mk(0, 4'hE, 4'h2, 0, 0));
        t = idle(); t.ihit = 0; t.redir = 1;
        add("redir_imiss", t, mk(1, 4'hF, 4'h3, 0, 0));
        t = idle(); t.mem_wen = 1; t.mem_rd = 3; t.id_rs = 3;
        add("fwd_no_stall", t, mk(1, 4'hF, 4'h0, 0, 0));

        foreach (vq[k]) begin
            do_reset();
            drive(vq[k].i);
            #1;
            cmp(vq[k].name, get_main(), vq[k].o);
        end

        // three data-miss cycles, then the hit
        do_reset();
        t = idle(); t.dren = 1;
        drive(t);
        for (int c = 0; c < 3; c++) begin
            #1;
            cmp("dmiss", get_main(), mk(0, 4'h0, 4'h0, 0, 0));
            @(negedge CLK);
        end
        t.dhit = 1;
        drive(t);
        #1;
        cmp("dmiss_hit", get_main(), mk(1, 4'hF, 4'h0, 0, 0));
        @(negedge CLK);
        drive(idle());
        #1;
        cmp("dmiss_after", get_main(), mk(1, 4'hF, 4'h0, 0, 0));
        chk("dmiss.stall_cnt", 32'(hif.stall_cnt), 3);

        // held load-use inputs give exactly one bubble
        do_reset();
        t = idle(); t.ex_memread = 1; t.ex_rd = 5; t.id_rt = 5;
        drive(t);
        #1;
        cmp("lu_first", get_main(), mk(0, 4'hE, 4'h2, 0, 0));
        @(negedge CLK);
        #1;
        cmp("lu_second", get_main(), mk(1, 4'hF, 4'h0, 0, 0));
        chk("lu.stall_cnt", 32'(hif.stall_cnt), 1);

        do_reset();
        t.redir = 1;
        drive(t);
        @(negedge CLK);
        drive(idle());
        #1;
        chk("redir.flush_cnt", 32'(hif.flush_cnt), 1);
        chk("redir.stall_cnt", 32'(hif.stall_cnt), 0);

        // halt freezes everything until reset
        do_reset();
        t = idle(); t.ihit = 0;
        drive(t);
        @(negedge CLK);
        t = idle(); t.halt = 1;
        drive(t);
        #1;
        cmp("halt_cycle", get_main(), mk(0, 4'h0, 4'h0, 0, 0));
        chk("halt_cycle.halted", 32'(hif.halted), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            t = idle(); t.ihit = 0; t.redir = 1;
            drive(t);
            #1;
            chk("halted", 32'(hif.halted), 1);
            cmp("halted", get_main(), mk(0, 4'h0, 4'h0, 0, 0));
            chk("halted.stall_cnt", 32'(hif.stall_cnt), 1);
            chk("halted.flush_cnt", 32'(hif.flush_cnt), 0);
        end
        nRST = 1'b0;
        #1;
        chk("halt_rst.halted", 32'(hif.halted), 0);
        chk("halt_rst.stall_cnt", 32'(hif.stall_cnt), 0);
        @(negedge CLK);
        nRST = 1'b1;
        drive(idle());
        #1;
        cmp("halt_release", get_main(), mk(1, 4'hF, 4'h0, 0, 0));

        // reset in the middle of a data wait
        do_reset();
        t = idle(); t.dren = 1;
        drive(t);
        @(negedge CLK);
        t.mem_wen = 1; t.mem_rd = 2; t.ex_rs = 2;
        drive(t);
        nRST = 1'b0;
        #1;
        cmp("rst_dwait", get_main(), mk(0, 4'h0, 4'h0, 0, 0));
        @(negedge CLK);
        nRST = 1'b1;
        drive(idle());
        #1;
        cmp("rst_dwait_release", get_main(), mk(1, 4'hF, 4'h0, 0, 0));

        // stall-only interlock build
        do_reset();
        t = idle(); t.mem_wen = 1; t.mem_rd = 3; t.id_rs = 3; t.ex_rs = 3;
        drive(t);
        #1;
        cmp("nofwd_ilk", get0(), mk(0, 4'hE, 4'h2, 0, 0));
        cmp("fwd_same", get_main(), mk(1, 4'hF, 4'h0, 2'b01, 0));

        // randomized run against the model
        do_reset();
        m1 = mreset();
        m0 = mreset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                nRST = 1'b0;
                drive(rnd());
                #1;
                cmp("rnd_rst", get_main(), mk(0, 4'h0, 4'h0, 0, 0));
                chk("rnd_rst.stall_cnt", 32'(hif.stall_cnt), 0);
                chk("rnd_rst.halted", 32'(hif.halted), 0);
                m1 = mreset();
                m0 = mreset();
                @(negedge CLK);
                nRST = 1'b1;
            end
            t = rnd();
            drive(t);
            #1;
            model(t, m1, 1'b1, e1, n1);
            model(t, m0, 1'b0, e0, n0);
            cmp("rnd", get_main(), e1);
            cmp("rnd_nofwd", get0(), e0);
            chk("rnd.stall_cnt", 32'(hif.stall_cnt), sat(m1.scnt, 16));
            chk("rnd.flush_cnt", 32'(hif.flush_cnt), sat(m1.fcnt, 16));
            chk("rnd.halted", 32'(hif.halted), 32'(m1.st == M_HALT));
            chk("rnd_nofwd.stall_cnt", 32'(if0.stall_cnt), sat(m0.scnt, 16));
            chk("rnd_nofwd.flush_cnt", 32'(if0.flush_cnt), sat(m0.fcnt, 16));
            chk("rnd_sat.stall_cnt", 32'(ifs.stall_cnt), sat(m1.scnt, 3));
            chk("rnd_sat.flush_cnt", 32'(ifs.flush_cnt), sat(m1.fcnt, 3));
            m1 = n1;
            m0 = n0;
            @(negedge CLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
